// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter and fetch controller.
// Drives a registered byte address into a combinational instruction memory,
// latches the returned word, and presents it downstream over valid/ready.
// One instruction is in flight at a time (IDLE -> FETCH -> ISSUE), so the
// issue rate is at most one instruction every two cycles.
//
// Handshake: instr/instr_pc are valid while instr_valid=1 and stay stable
// until the cycle where instr_valid & instr_ready are both high; that cycle
// is the transfer. redirect_valid/redirect_target are only looked at in the
// transfer cycle. pc_clear overrides everything, including a transfer.
module fetch_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int STEP     = 4,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              pc_clear,
  output logic [ADDR_W-1:0] imem_address,
  input  logic [31:0]       imem_instruction,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [CNT_W-1:0]  retired,
  output logic              misaligned,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] STEP_V  = ADDR_W'(STEP);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pc;
  logic              handshake;

  // State register; pc_clear is folded into the next-state logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: IDLE waits for run, FETCH always issues, ISSUE waits for transfer.
  always_comb begin
    state_nxt = state;
    if (pc_clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (run) state_nxt = FETCH;
        FETCH:   state_nxt = ISSUE;
        ISSUE:   if (handshake) state_nxt = run ? FETCH : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    instr_valid = (state == ISSUE);
    handshake   = instr_valid & instr_ready;
    dbg_state   = state;
  end

  // The memory address is the pc register itself.
  assign imem_address = pc;

  // Datapath: pc update, instruction latch, retire counter, misalignment flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= PC_INIT;
      instr      <= '0;
      instr_pc   <= '0;
      retired    <= '0;
      misaligned <= 1'b0;
    end else if (pc_clear) begin
      // A transfer in this same cycle is deliberately not counted.
      pc         <= PC_INIT;
      retired    <= '0;
      misaligned <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          instr    <= imem_instruction;
          instr_pc <= pc;
          pc       <= pc + STEP_V;  // wraps modulo 2^ADDR_W
        end
        ISSUE: begin
          if (handshake) begin
            if (retired != {CNT_W{1'b1}}) retired <= retired + CNT_W'(1);
            if (redirect_valid) begin
              pc <= {redirect_target[ADDR_W-1:2], 2'b00};
              if (redirect_target[1:0] != 2'b00) misaligned <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter and fetch controller for the CPU. It drives the byte address into the combinational instruction memory (8-bit address, 32-bit instruction, word-aligned at multiples of 4).
- Latches the returned instruction and presents it to decode/execute over a valid/ready handshake.
- Takes jump redirects back from execute.
- One instruction is in flight at a time; issue rate is at most one instruction per 2 cycles.

Parameters:
- ADDR_W, 8, PC/address width; the PC wraps modulo 2^ADDR_W.
- STEP, 4, byte increment between sequential instructions.
- RESET_PC, 0, PC value after reset or pc_clear.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; 1 = fetch and issue, 0 = pause after the current handshake completes.
- pc_clear  in  1  synchronous; reloads RESET_PC, drops any held instruction, goes to IDLE.
- imem_address  out  ADDR_W  address to instruction memory; registered.
- imem_instruction  in  32  combinational read data for imem_address.
- instr  out  32  issued instruction; held stable while instr_valid=1 and instr_ready=0.
- instr_pc  out  ADDR_W  address of instr.
- instr_valid  out  1  instr is valid.
- instr_ready  in  1  execute accepts instr this cycle.
- redirect_valid  in  1  jump taken by the instruction being accepted; qualified by instr_valid & instr_ready.
- redirect_target  in  ADDR_W  jump destination byte address.
- retired  out  CNT_W  count of accepted instructions; saturates at all-ones.
- misaligned  out  1  sticky; set when a redirect target has nonzero bits [1:0].

Behaviour:
- Reset (rst_n=0, asynchronous) sets: state=IDLE, pc=RESET_PC, imem_address=RESET_PC, instr=0, instr_pc=0, instr_valid=0, retired=0, misaligned=0.
- imem_address always equals the registered pc.
- States: IDLE, FETCH, ISSUE.
- IDLE:
  - instr_valid=0.
  - run=1 -> FETCH on the next edge.
  - run=0 -> stay in IDLE.
- FETCH (1 cycle):
  - instr<=imem_instruction, instr_pc<=pc, instr_valid<=1.
  - pc<=pc+STEP, truncated to ADDR_W, so 252+4 wraps to 0.
  - -> ISSUE.
- ISSUE:
  - instr_valid=1. instr and instr_pc are held until the handshake completes.
  - Handshake = instr_valid & instr_ready:
    - retired<=retired+1, saturating.
    - If redirect_valid=1: pc<=redirect_target with bits [1:0] forced to 0. If the original bits [1:0] were nonzero, set misaligned<=1.
    - If redirect_valid=0: pc keeps its sequential value.
    - Next state: run=1 -> FETCH; run=0 -> IDLE. instr_valid<=0 in both cases.
  - No handshake: stay in ISSUE. redirect_valid is ignored.
- Latency and rate:
  - instr_valid rises 2 edges after run is sampled high in IDLE.
  - Back-to-back issue with instr_ready tied high gives 1 instruction per 2 cycles.
  - The first fetch after a redirect reads redirect_target.
- run deasserted:
  - Never drops a valid instruction. ISSUE waits for its handshake before going to IDLE.
  - In FETCH, the fetch completes and the block goes to ISSUE.
  - pc is preserved, so the next run resumes at the next address.
- pc_clear:
  - Has priority over all other inputs in every state.
  - Next edge: pc=RESET_PC, instr_valid=0, state=IDLE, retired=0, misaligned=0.
  - An instruction presented in the same cycle as pc_clear is not counted, even if instr_ready=1.
- Instruction 0 (NOP) is issued like any other instruction; no decode happens in this block.
- Async reset mid-operation aborts immediately with no handshake. The first fetch after rst_n release is RESET_PC, once run is high.

Test Plan:
1. Reset, then run=1 with instr_ready=1. Memory: 0 MOV, 4 ACC, 8 JMP to 4. Required response:
   - instr_pc sequence 0,4,8, with instr_valid one cycle in every two.
   - With redirect_valid=1 and target=4 on the JMP, the sequence continues 4,8,4,8...
   - retired increments once per handshake.
2. Stall: hold instr_ready=0 for 5 cycles on instr_pc=4 -> instr and instr_pc stay constant, pc=8, retired unchanged. Then ready=1 -> next instr_pc=8.
3. Wrap: pc_clear, then redirect to 252, with sequential memory -> instr_pc sequence 252,0,4.
4. Pause: drop run during ISSUE with ready=0 -> instruction held. ready=1 -> IDLE with pc retained. run=1 -> resumes at the next address with no skip or repeat.
5. Misaligned redirect: target=8'd6 -> next instr_pc=4 and misaligned=1, sticky until pc_clear.
6. Reset/clear mid-operation:
   - rst_n low while in ISSUE -> all outputs reach reset values without waiting for a clock edge.
   - pc_clear with instr_ready=1 in the same cycle -> retired=0, instr_valid=0, state IDLE.
